instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs decoded instruction fields plus a 32-bit immediate into a 32-bit RV32I instruction word.
- Covers exactly the formats the immediate generator decodes: I-arith (including shifts), I-load, S, B and LUI.
- Used by the self-test instruction feeder and by the bench to build instruction-memory images on the fly.
- Valid/ready on both sides; a 2-entry output FIFO decouples the producer from the consumer.

Parameters:
- ERRCNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request carries valid fields
- in_ready  out  1  encoder accepts the request this cycle
- fmt  in  3  0=I-arith, 1=I-load, 2=S, 3=B, 4=LUI, 5..7 illegal
- funct3  in  3  placed in bits [14:12] (ignored for LUI)
- arith  in  1  SRAI select; used only for I-arith with funct3=101
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  32  byte immediate, signed for I/S/B; full upper value for LUI
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer takes the head
- instr  out  32  encoded word at FIFO head
- err  out  1  head entry had an unrepresentable immediate or illegal fmt
- err_cnt  out  ERRCNT_W  count of errored requests accepted since reset

Behaviour:
- Reset:
  - FIFO count=0; out_valid=0, instr=0, err=0, err_cnt=0.
  - in_ready=0 while reset is high.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshakes:
  - Accept when in_valid & in_ready at a rising edge.
  - Pop when out_valid & out_ready at a rising edge.
  - in_ready = (count<2) & ~reset. It does not depend on out_ready, so there is no combinational path from output to input.
- Latency and ordering:
  - An entry accepted at edge N is visible with out_valid=1 after edge N (registered); the encoding logic is combinational before the FIFO write.
  - Throughput is 1 per cycle while out_ready=1. Order is strictly FIFO.
- Simultaneous push and pop:
  - With count=1 both occur and count stays 1.
  - With count=2 no push is possible; a pop takes count to 1.
  - With count=0 a push makes count 1; a pop is impossible.
- While out_valid=0, instr and err hold their last values.
- Encoding, opcode per fmt: 0010011, 0000011, 0100011, 1100011, 0110111.
- I-arith:
  - funct3=001 or 101: [31:25]={1'b0, arith & (funct3==101), 5'b0}, [24:20]=imm[4:0]. Error if imm[31:5]!=0.
  - Any other funct3: [31:20]=imm[11:0]. Error if imm is not the sign extension of imm[11:0].
- I-load: [31:20]=imm[11:0], same 12-bit range check as I-arith.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2 in [24:20], same 12-bit range check.
- B:
  - Bit placement: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - Error if imm[0]=1 or imm is not the sign extension of imm[12:0].
- LUI: [31:12]=imm[31:12], [11:7]=rd. Error if imm[11:0]!=0.
- Field placement: rd in [11:7] for I/LUI; rs1 in [19:15] for I/S/B; funct3 in [14:12] for I/S/B.
- Errored requests are still accepted and emitted with truncated fields and err=1.
- Illegal fmt: instr=0, err=1.
- err_cnt increments on each accepted errored request and saturates at all-ones (no wrap).
- Reset mid-stream: FIFO contents are discarded and out_valid drops on the next edge. err_cnt clears.

Test Plan:
- ADDI: fmt=0, funct3=0, rd=1, rs1=0, imm=0xFFFFFFFF -> instr=0xFFF00093, err=0 after 1 cycle.
- SW: fmt=2, funct3=2, rs1=2, rs2=5, imm=8 -> instr=0x00512423. Then BEQ: fmt=3, funct3=0, rs1=1, rs2=2, imm=-4 -> instr=0xFE208EE3.
- SRAI: fmt=0, funct3=5, arith=1, rd=3, rs1=4, imm=7 -> instr=0x40725193. LUI: fmt=4, rd=5, imm=0x12345000 -> instr=0x123452B7.
- Errors:
  - ADDI imm=2048 -> err=1, instr[31:20]=0x800, err_cnt=1.
  - BEQ imm=3 -> err=1, err_cnt=2.
  - fmt=6 -> instr=0, err=1, err_cnt=3.
- Backpressure: hold out_ready=0 and push 3 back-to-back requests. in_ready drops after the second accept. Release out_ready: the two entries drain in order, then the third is accepted. No loss and no duplication.
- Reset with 2 entries queued -> out_valid=0, err_cnt=0 next cycle; in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction producer and the encoder.
// master drives the request fields and consumer ready; slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [2:0]  funct3;
  logic        arith;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, fmt, funct3, arith, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, fmt, funct3, arith, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields + immediate into an instruction word; 1 cycle to out_valid via a 2-entry FIFO.
// in_ready depends only on FIFO occupancy, so output backpressure never reaches the input combinationally.
module instr_encoder #(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_encoder_if.slave      bus,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BRCH = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits12;
  logic        fits13;
  logic        shamt_op;
  logic        push;
  logic        pop;

  // Head entry lives in the output registers; skid holds the second entry.
  logic [31:0] skid_instr;
  logic        skid_err;
  logic        skid_vld;

  assign fits12   = (bus.imm[31:11] == '0) || (bus.imm[31:11] == '1);
  assign fits13   = (bus.imm[31:12] == '0) || (bus.imm[31:12] == '1);
  assign shamt_op = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (bus.fmt)
      3'd0: begin
        if (shamt_op) begin
          enc_instr = {1'b0, bus.arith & (bus.funct3 == 3'b101), 5'b0, bus.imm[4:0],
                       bus.rs1, bus.funct3, bus.rd, OP_IMM};
          enc_err   = |bus.imm[31:5];
        end else begin
          enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_IMM};
          enc_err   = ~fits12;
        end
      end
      3'd1: begin
        enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
        enc_err   = ~fits12;
      end
      3'd2: begin
        enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_STOR};
        enc_err   = ~fits12;
      end
      3'd3: begin
        enc_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], OP_BRCH};
        enc_err   = bus.imm[0] | ~fits13;
      end
      3'd4: begin
        enc_instr = {bus.imm[31:12], bus.rd, OP_LUI};
        enc_err   = |bus.imm[11:0];
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  assign bus.in_ready = ~reset & ~(bus.out_valid & skid_vld);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.instr     <= '0;
      bus.err       <= 1'b0;
      skid_vld      <= 1'b0;
      skid_instr    <= '0;
      skid_err      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (pop) begin
        if (skid_vld) begin
          bus.instr  <= skid_instr;
          bus.err    <= skid_err;
          skid_vld   <= push;
          if (push) begin
            skid_instr <= enc_instr;
            skid_err   <= enc_err;
          end
        end else begin
          bus.out_valid <= push;
          if (push) begin
            bus.instr <= enc_instr;
            bus.err   <= enc_err;
          end
        end
      end else if (push) begin
        if (!bus.out_valid) begin
          bus.out_valid <= 1'b1;
          bus.instr     <= enc_instr;
          bus.err       <= enc_err;
        end else begin
          skid_vld   <= 1'b1;
          skid_instr <= enc_instr;
          skid_err   <= enc_err;
        end
      end

      if (push && enc_err && !(&err_cnt))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, errors, backpressure, reset, then random traffic.
module tb_instr_encoder;
  localparam int ECW   = 3;
  localparam int ECMAX = (1 << ECW) - 1;

  logic           clk;
  logic           reset;
  logic [ECW-1:0] err_cnt;
  instr_encoder_if bus ();

  instr_encoder #(.ERRCNT_W(ECW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  int          or_mode = 0;
  logic [31:0] q_i[$];
  logic        q_e[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoding built from field positions with arithmetic and numeric range tests.
  task automatic model(input logic [2:0] f, input logic [2:0] f3, input logic ar,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, output logic [31:0] w, output logic e);
    int s;
    s = $signed(im);
    w = 32'h0;
    e = 1'b1;
    case (f)
      3'd0: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e = im > 32'd31;
          w = ((ar && f3 == 3'd5) ? (32'h20 << 25) : 32'h0) | ((im & 32'h1f) << 20);
        end else begin
          e = (s < -2048) || (s > 2047);
          w = (im & 32'hfff) << 20;
        end
        w = w | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
      end
      3'd1: begin
        e = (s < -2048) || (s > 2047);
        w = ((im & 32'hfff) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h03;
      end
      3'd2: begin
        e = (s < -2048) || (s > 2047);
        w = (((im >> 5) & 32'h7f) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
            (32'(f3) << 12) | ((im & 32'h1f) << 7) | 32'h23;
      end
      3'd3: begin
        e = (im % 2 != 0) || (s < -4096) || (s > 4095);
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25) |
            (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) |
            (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      end
      3'd4: begin
        e = (im % 4096) != 0;
        w = (im & 32'hfffff000) | (32'(d) << 7) | 32'h37;
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
  endtask

  task automatic drive(input logic [2:0] f, input logic [2:0] f3, input logic ar,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    bus.fmt      = f;
    bus.funct3   = f3;
    bus.arith    = ar;
    bus.rd       = d;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.imm      = im;
    bus.in_valid = 1'b1;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept(input logic [31:0] ei, input logic ee);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q_i.push_back(ei);
    q_e.push_back(ee);
    if (ee && exp_cnt < ECMAX) exp_cnt++;
    #1;
    bus.in_valid = 1'b0;
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  task automatic send(input logic [2:0] f, input logic [2:0] f3, input logic ar,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] ei, input logic ee);
    drive(f, f3, ar, d, s1, s2, im);
    wait_accept(ei, ee);
  endtask

  task automatic send_rand();
    logic [2:0]  f, f3;
    logic        ar;
    logic [4:0]  d, s1, s2;
    logic [31:0] im, ei;
    logic        ee;
    int          v;
    f  = 3'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    ar = 1'($urandom_range(0, 1));
    d  = 5'($urandom_range(0, 31));
    s1 = 5'($urandom_range(0, 31));
    s2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0: im = $urandom;
      1: begin
        v  = int'($urandom_range(0, 12000)) - 6000;
        im = v;
      end
      2: im = $urandom_range(0, 40);
      default: im = ($urandom & 32'hfffff000) | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
    endcase
    model(f, f3, ar, d, s1, s2, im, ei, ee);
    send(f, f3, ar, d, s1, s2, im, ei, ee);
  endtask

  // Returns just after a rising edge once every expected entry has left the DUT.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (q_i.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries outstanding, expected 0", q_i.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Consumer ready: applied 2ns after each edge so mode changes made at +1ns take effect that cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    logic [31:0] ei;
    logic        ee;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (q_i.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got instr %h, expected no output", bus.instr);
        end else begin
          ei = q_i.pop_front();
          ee = q_e.pop_front();
          check("instr", bus.instr, ei);
          check("err", 32'(bus.err), 32'(ee));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.fmt      = '0;
    bus.funct3   = '0;
    bus.arith    = 1'b0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Directed encodings
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hffffffff, 32'hfff00093, 1'b0);
    send(3'd2, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,        32'h00512423, 1'b0);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4,      32'hfe208ee3, 1'b0);
    send(3'd0, 3'd5, 1'b1, 5'd3, 5'd4, 5'd0, 32'd7,        32'h40725193, 1'b0);
    send(3'd4, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452b7, 1'b0);

    // Unrepresentable immediates and illegal fmt
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b1);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,        32'h00208163, 1'b1);
    send(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0,        32'h00000000, 1'b1);
    drain();
    check("err_cnt_after_errors", 32'(err_cnt), 32'd3);

    // Backpressure: two entries fill the FIFO, the third waits for a pop
    or_mode = 1;
    send(3'd1, 3'd2, 1'b0, 5'd7, 5'd8, 5'd0, 32'd16, 32'h01042383, 1'b0);
    send(3'd1, 3'd4, 1'b0, 5'd9, 5'd10, 5'd0, -32'sd1, 32'hfff54483, 1'b0);
    drive(3'd0, 3'd1, 1'b0, 5'd2, 5'd2, 5'd0, 32'd31);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
      check("bp_head_held", bus.instr, 32'h01042383);
    end
    @(posedge clk);
    #1;
    or_mode = 0;
    wait_accept(32'h01f11113, 1'b0);
    drain();

    // Reset with two entries queued
    or_mode = 1;
    send(3'd2, 3'd0, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4096, 32'h00418023, 1'b1);
    send(3'd4, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'habcde000, 32'habcde337, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    q_i.delete();
    q_e.delete();
    exp_cnt = 0;
    reset   = 1'b0;
    or_mode = 0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    check("mid_rst_in_ready_after", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Random traffic with random consumer stalls; err_cnt saturates along the way
    or_mode = 2;
    for (int n = 0; n < 300; n++) send_rand();
    or_mode = 0;
    drain();
    check("final_queue_empty", 32'(q_i.size()), 32'h0);
    check("final_err_cnt", 32'(err_cnt), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
